// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: the ALU opcode space (including the
// multiply/divide extensions), the multdiv FSM state encoding and the fixed
// start-to-ready latency of the multdiv unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

  // Clocks from the start edge to the rising edge of data_resultRDY.
  localparam int MULTDIV_LATENCY = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/div_restoring_dp.sv
// Restoring divider datapath working on unsigned magnitudes.
//   clock, resetn : clock and asynchronous active-low reset
//   load          : capture dividend/divisor, clear the partial remainder
//   step          : perform one restoring iteration (one quotient bit)
//   dividend      : dividend magnitude
//   divisor       : divisor magnitude
//   quotient      : quotient magnitude, valid after WIDTH steps
// load has priority over step. A zero divisor yields all-ones; the caller
// is expected to override that case.
module div_restoring_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] diff;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    // One spare bit above the remainder so the trial subtraction's sign is
    // never lost when the shifted remainder reaches 2^WIDTH.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {2'b00, dvs_q};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[WIDTH+1]) begin
        rem_d = diff[WIDTH:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide unit for the execute stage.
//   clock, resetn  : clock and asynchronous active-low reset
//   data_operandA  : multiplicand / dividend (signed)
//   data_operandB  : multiplier / divisor (signed)
//   ctrl_MULT      : start-multiply pulse
//   ctrl_DIV       : start-divide pulse
//   data_result    : low WIDTH bits of the product, or the quotient
//   data_exception : multiply overflow, divide-by-zero or divide overflow
//   data_resultRDY : one-cycle result-valid pulse
//   busy           : operation in progress
//   dbg_state      : current FSM state
// Handshake: a start is a single-cycle pulse on ctrl_MULT/ctrl_DIV sampled
// at a rising edge in any state (MULT wins if both are high; a start while
// busy aborts the running op). Operands are only sampled at that edge.
// Exactly MULTDIV_LATENCY edges later data_resultRDY is high for one cycle
// with data_result/data_exception valid; those hold until the next
// completion or reset. There is no back-pressure.
module multdiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output md_state_e        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_END       = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN       = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic               div_zero_q, div_zero_d;
  logic               div_ovf_q, div_ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic               start;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               dp_step;
  logic [WIDTH-1:0]   quo_mag;
  logic               mul_ovf;

  assign start = ctrl_MULT | ctrl_DIV;

  // Two's-complement magnitudes; INT_MIN maps to itself, read as unsigned.
  assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  assign dp_step = !start && (state_q == ST_DIV) && (cnt_q != CNT_END);

  // Product fits in signed WIDTH bits only if the top WIDTH+1 bits agree.
  assign mul_ovf = !((acc_q[2*WIDTH-1:WIDTH-1] == '0) ||
                     (acc_q[2*WIDTH-1:WIDTH-1] == '1));

  div_restoring_dp #(.WIDTH(WIDTH)) u_div_dp (
    .clock    (clock),
    .resetn   (resetn),
    .load     (start),
    .step     (dp_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quo_mag)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    result_d   = result_q;
    exc_d      = exc_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;

    if (start) begin
      state_d    = ctrl_MULT ? ST_MUL : ST_DIV;
      cnt_d      = '0;
      acc_d      = '0;
      mcand_d    = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      mplier_d   = data_operandB;
      neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero_d = (data_operandB == '0);
      div_ovf_d  = (data_operandA == INT_MIN) && (data_operandB == '1);
      rdy_d      = 1'b0;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_MUL: begin
          if (cnt_q == CNT_END) begin
            state_d  = ST_DONE;
            result_d = acc_q[WIDTH-1:0];
            exc_d    = mul_ovf;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end else begin
            // The multiplier's sign bit carries weight -2^(WIDTH-1), so its
            // partial product is subtracted on the final iteration.
            if (mplier_q[0]) begin
              if (cnt_q == CNT_LAST_STEP) acc_d = acc_q - mcand_q;
              else                        acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (cnt_q == CNT_END) begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
            if (div_zero_q) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else if (div_ovf_q) begin
              result_d = INT_MIN;
              exc_d    = 1'b1;
            end else begin
              result_d = neg_q ? (~quo_mag + 1'b1) : quo_mag;
              exc_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rdy_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vectors plus randomized
// operations, all compared against a plain-arithmetic reference model.
module tb_multdiv_unit;
  import alu_pkg::*;

  logic        clock;
  logic        resetn;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  md_state_e   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {exception, result}
  logic [32:0] exp_q[$];

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: full-precision signed arithmetic.
  function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    logic [31:0] lo;
    int q;
    if (is_mul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      return {(p != longint'($signed(lo))), lo};
    end else if (b == 32'h0) begin
      return {1'b1, 32'h0};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {1'b1, 32'h8000_0000};
    end else begin
      q = $signed(a) / $signed(b);
      return {1'b0, 32'(q)};
    end
  endfunction

  // Called just after an edge; returns just after the start edge with the
  // operand bus already scrambled.
  task automatic start_op(input bit mul, input bit div, input logic [31:0] a,
                          input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called just after the start edge; waits (bounded) for RDY and checks
  // latency, busy, the scoreboard entry and the single-cycle pulse.
  task automatic wait_result(input string tag);
    int cyc;
    logic [32:0] e;
    cyc = 0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    while (!data_resultRDY && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 32) check({tag, "_busy_e32"}, 32'(busy), 32'd1);
    end
    check({tag, "_latency"}, 32'(cyc), 32'(MULTDIV_LATENCY));
    if (exp_q.size() == 0) e = '0;
    else e = exp_q.pop_front();
    check({tag, "_result"}, data_result, e[31:0]);
    check({tag, "_exc"}, 32'(data_exception), 32'(e[32]));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    check({tag, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
    check({tag, "_hold"}, data_result, e[31:0]);
  endtask

  task automatic do_op(input string tag, input bit mul, input logic [31:0] a,
                       input logic [31:0] b);
    exp_q.push_back(model(mul, a, b));
    start_op(mul, !mul, a, b);
    wait_result(tag);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'h0 - 32'($urandom_range(1, 20));
      2:       return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rdy_seen;
    bit mul;
    logic [31:0] a, b;

    resetn        = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'h0);
    check("reset_exc", 32'(data_exception), 32'h0);
    check("reset_rdy", 32'(data_resultRDY), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    @(posedge clock); #1;

    // directed vectors
    do_op("mul_7xm3",      1'b1, 32'd7,          32'hFFFF_FFFD);
    do_op("mul_ovf_2p32",  1'b1, 32'h0001_0000,  32'h0001_0000);
    do_op("mul_ovf_2p31",  1'b1, 32'h4000_0000,  32'd2);
    do_op("mul_min_exact", 1'b1, 32'hFFFF_8000,  32'h0001_0000);
    do_op("div_m7_2",      1'b0, 32'hFFFF_FFF9,  32'd2);
    do_op("div_100_m7",    1'b0, 32'd100,        32'hFFFF_FFF9);
    do_op("div_min_m1",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF);
    do_op("div_by_zero",   1'b0, 32'd5,          32'd0);

    // restart while busy: only the DIV completes
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    rdy_seen = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_seen++;
    end
    check("abort_no_rdy", 32'(rdy_seen), 32'd0);
    exp_q.push_back({1'b0, 32'd14});
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_result("restart_div");

    // both starts together -> multiply
    exp_q.push_back({1'b0, 32'd18});
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_result("both_ctrl");

    // asynchronous reset mid-multiply
    start_op(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_result", data_result, 32'h0);
    check("arst_exc", 32'(data_exception), 32'h0);
    check("arst_rdy", 32'(data_resultRDY), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(posedge clock); #1;
    resetn = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_seen++;
    end
    check("arst_no_rdy", 32'(rdy_seen), 32'd0);
    check("arst_idle_busy", 32'(busy), 32'd0);
    do_op("mul_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      mul = 1'($urandom_range(0, 1));
      a   = rand_operand();
      b   = rand_operand();
      do_op(mul ? "rand_mul" : "rand_div", mul, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
